// File: rtl/mips_ctrl_pkg.sv
// Shared control definitions for the MIPS pipeline control blocks:
// sequencer states, opcode/funct constants and the register dependency test.
package mips_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN  = 2'd0,
      HOLD = 2'd1,
      WAIT = 2'd2
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;

   localparam logic [5:0] FN_JR    = 6'h08;
   localparam logic [5:0] FN_JALR  = 6'h09;

   // True when destination dst feeds a source the ID instruction actually reads.
   // $0 is hardwired, so it never creates a dependency.
   function automatic logic reg_dep(input logic [4:0] dst,
                                    input logic [4:0] rs,
                                    input logic [4:0] rt,
                                    input logic       use_rs,
                                    input logic       use_rt);
      return (dst != 5'd0) && ((use_rs && (dst == rs)) || (use_rt && (dst == rt)));
   endfunction

endpackage

// File: rtl/hazard_stall_detect.sv
// Combinational hazard classifier: number of stall cycles the ID instruction
// needs before its operands can be forwarded.
module hazard_stall_detect (
   input  logic [5:0] id_opcode,
   input  logic [5:0] id_funct,
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic       id_use_rs,
   input  logic       id_use_rt,
   input  logic       ex_mem_read,
   input  logic       ex_reg_write,
   input  logic [4:0] ex_reg_wr_addr,
   input  logic       mem_mem_read,
   input  logic [4:0] mem_reg_wr_addr,
   output logic [1:0] stall_n
);
   import mips_ctrl_pkg::*;

   logic is_br;
   logic is_jr;
   logic dep_ex;
   logic dep_mem;

   // Decode branch class and pick the first matching stall rule.
   always_comb begin
      is_br   = (id_opcode == OP_BEQ) || (id_opcode == OP_BNE);
      is_jr   = (id_opcode == OP_RTYPE) && ((id_funct == FN_JR) || (id_funct == FN_JALR));
      dep_ex  = reg_dep(ex_reg_wr_addr, id_rs, id_rt, id_use_rs, id_use_rt);
      dep_mem = reg_dep(mem_reg_wr_addr, id_rs, id_rt, id_use_rs, id_use_rt);
      stall_n = 2'd0;
      if ((is_br || is_jr) && ex_mem_read && dep_ex) begin
         stall_n = 2'd2;
      end else if (ex_reg_write && dep_ex) begin
         stall_n = 2'd1;
      end else if ((is_br || is_jr) && mem_mem_read && dep_mem) begin
         stall_n = 2'd1;
      end
   end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard sequencer: PC/IF_ID enables, ID_EX bubbles and IF_ID flush,
// with a RUN/HOLD/WAIT FSM for multi-cycle stalls and memory-wait freeze.
// Optional performance counters are enabled with `define HAZARD_PERF_EN.
module hazard_stall_ctrl #(
   parameter int unsigned PERF_W = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [5:0]        IF_ID_OpCode,
   input  logic [5:0]        IF_ID_Funct,
   input  logic [4:0]        IF_ID_Rs,
   input  logic [4:0]        IF_ID_Rt,
   input  logic              IF_ID_UseRs,
   input  logic              IF_ID_UseRt,
   input  logic              ID_EX_MemRead,
   input  logic              ID_EX_RegWrite,
   input  logic [4:0]        ID_EX_RegWrAddr,
   input  logic              EX_MEM_MemRead,
   input  logic [4:0]        EX_MEM_RegWrAddr,
   input  logic              BranchTaken,
   input  logic              Jump,
   input  logic              MemWait,
   output logic              PC_Write,
   output logic              IF_ID_Write,
   output logic              ID_EX_Flush,
   output logic              IF_ID_Flush,
   output logic              Stalling,
   output logic [PERF_W-1:0] StallCount,
   output logic [PERF_W-1:0] FlushCount
);
   import mips_ctrl_pkg::*;

   state_t     state;
   state_t     saved_state;
   state_t     eff_state;
   logic [1:0] rem;
   logic [1:0] stall_n;
   logic       issue;

   hazard_stall_detect u_detect (
      .id_opcode       (IF_ID_OpCode),
      .id_funct        (IF_ID_Funct),
      .id_rs           (IF_ID_Rs),
      .id_rt           (IF_ID_Rt),
      .id_use_rs       (IF_ID_UseRs),
      .id_use_rt       (IF_ID_UseRt),
      .ex_mem_read     (ID_EX_MemRead),
      .ex_reg_write    (ID_EX_RegWrite),
      .ex_reg_wr_addr  (ID_EX_RegWrAddr),
      .mem_mem_read    (EX_MEM_MemRead),
      .mem_reg_wr_addr (EX_MEM_RegWrAddr),
      .stall_n         (stall_n)
   );

   // Once MemWait drops, WAIT already behaves as the saved state, so the
   // pipe resumes in the same cycle and no extra frozen cycle is added.
   always_comb begin
      eff_state = (state == WAIT) ? saved_state : state;
      issue     = !MemWait && ((eff_state == HOLD) ||
                               ((eff_state == RUN) && (stall_n != 2'd0)));
   end

   // Output mux: reset forcing, memory freeze, stall, or normal flow.
   always_comb begin
      PC_Write    = 1'b0;
      IF_ID_Write = 1'b0;
      ID_EX_Flush = 1'b0;
      IF_ID_Flush = 1'b0;
      Stalling    = 1'b0;
      if (!reset_n) begin
         ID_EX_Flush = 1'b1;
         IF_ID_Flush = 1'b1;
      end else if (!MemWait) begin
         if (issue) begin
            ID_EX_Flush = 1'b1;
            Stalling    = 1'b1;
         end else begin
            PC_Write    = 1'b1;
            IF_ID_Write = 1'b1;
            IF_ID_Flush = BranchTaken | Jump;
         end
      end
   end

   // Sequencer: stall length bookkeeping and WAIT entry/exit.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state       <= RUN;
         saved_state <= RUN;
         rem         <= '0;
      end else if (MemWait) begin
         saved_state <= eff_state;
         state       <= WAIT;
      end else begin
         case (eff_state)
            HOLD: begin
               rem   <= rem - 2'd1;
               state <= (rem == 2'd1) ? RUN : HOLD;
            end
            default: begin
               state <= RUN;
               if (stall_n != 2'd0) begin
                  rem <= stall_n - 2'd1;
                  if (stall_n > 2'd1) begin
                     state <= HOLD;
                  end
               end
            end
         endcase
      end
   end

`ifdef HAZARD_PERF_EN
   logic [PERF_W-1:0] stall_cnt;
   logic [PERF_W-1:0] flush_cnt;

   // Count bubble and squash cycles; frozen while memory is waiting.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else if (!MemWait) begin
         if (ID_EX_Flush) begin
            stall_cnt <= stall_cnt + PERF_W'(1);
         end
         if (IF_ID_Flush) begin
            flush_cnt <= flush_cnt + PERF_W'(1);
         end
      end
   end

   assign StallCount = stall_cnt;
   assign FlushCount = flush_cnt;
`else
   assign StallCount = '0;
   assign FlushCount = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: reference model plus directed
// scenarios. Honours HAZARD_PERF_EN for the counter expectations.
module tb_hazard_stall_ctrl;
   localparam int unsigned PERF_W = 32;

   logic              clk = 1'b0;
   logic              reset_n;
   logic [5:0]        IF_ID_OpCode;
   logic [5:0]        IF_ID_Funct;
   logic [4:0]        IF_ID_Rs;
   logic [4:0]        IF_ID_Rt;
   logic              IF_ID_UseRs;
   logic              IF_ID_UseRt;
   logic              ID_EX_MemRead;
   logic              ID_EX_RegWrite;
   logic [4:0]        ID_EX_RegWrAddr;
   logic              EX_MEM_MemRead;
   logic [4:0]        EX_MEM_RegWrAddr;
   logic              BranchTaken;
   logic              Jump;
   logic              MemWait;
   logic              PC_Write;
   logic              IF_ID_Write;
   logic              ID_EX_Flush;
   logic              IF_ID_Flush;
   logic              Stalling;
   logic [PERF_W-1:0] StallCount;
   logic [PERF_W-1:0] FlushCount;

   int unsigned checks = 0;
   int unsigned passes = 0;
   bit          started = 1'b0;

   // model: stall cycles still owed after the current one, and event tallies
   int          m_pending = 0;
   logic [31:0] m_stalls  = 0;
   logic [31:0] m_flushes = 0;

   hazard_stall_ctrl #(.PERF_W(PERF_W)) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .IF_ID_OpCode     (IF_ID_OpCode),
      .IF_ID_Funct      (IF_ID_Funct),
      .IF_ID_Rs         (IF_ID_Rs),
      .IF_ID_Rt         (IF_ID_Rt),
      .IF_ID_UseRs      (IF_ID_UseRs),
      .IF_ID_UseRt      (IF_ID_UseRt),
      .ID_EX_MemRead    (ID_EX_MemRead),
      .ID_EX_RegWrite   (ID_EX_RegWrite),
      .ID_EX_RegWrAddr  (ID_EX_RegWrAddr),
      .EX_MEM_MemRead   (EX_MEM_MemRead),
      .EX_MEM_RegWrAddr (EX_MEM_RegWrAddr),
      .BranchTaken      (BranchTaken),
      .Jump             (Jump),
      .MemWait          (MemWait),
      .PC_Write         (PC_Write),
      .IF_ID_Write      (IF_ID_Write),
      .ID_EX_Flush      (ID_EX_Flush),
      .IF_ID_Flush      (IF_ID_Flush),
      .Stalling         (Stalling),
      .StallCount       (StallCount),
      .FlushCount       (FlushCount)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
   endtask

   // Stall cycles the ID instruction needs, straight from the hazard rules.
   function automatic int needed_stalls();
      bit branchy;
      bit ex_dep;
      bit mem_dep;
      branchy = (IF_ID_OpCode == 6'h04) || (IF_ID_OpCode == 6'h05) ||
                ((IF_ID_OpCode == 6'h00) && (IF_ID_Funct == 6'h08 || IF_ID_Funct == 6'h09));
      ex_dep  = (ID_EX_RegWrAddr != 0) &&
                ((IF_ID_UseRs && ID_EX_RegWrAddr == IF_ID_Rs) || (IF_ID_UseRt && ID_EX_RegWrAddr == IF_ID_Rt));
      mem_dep = (EX_MEM_RegWrAddr != 0) &&
                ((IF_ID_UseRs && EX_MEM_RegWrAddr == IF_ID_Rs) || (IF_ID_UseRt && EX_MEM_RegWrAddr == IF_ID_Rt));
      if (branchy && ID_EX_MemRead && ex_dep) return 2;
      if (ID_EX_RegWrite && ex_dep) return 1;
      if (branchy && EX_MEM_MemRead && mem_dep) return 1;
      return 0;
   endfunction

   // Compare every cycle mid-period, then advance the model for the coming edge.
   always @(negedge clk) begin
      if (started) begin
         logic e_pc, e_ifw, e_bub, e_sq, e_st;
         int   n;
         n = needed_stalls();
         if (!reset_n) begin
            {e_pc, e_ifw, e_bub, e_sq, e_st} = 5'b00110;
         end else if (MemWait) begin
            {e_pc, e_ifw, e_bub, e_sq, e_st} = 5'b00000;
         end else if (m_pending > 0 || n > 0) begin
            {e_pc, e_ifw, e_bub, e_sq, e_st} = 5'b00101;
         end else begin
            {e_pc, e_ifw, e_bub, e_st} = 4'b1100;
            e_sq = BranchTaken | Jump;
         end
         chk("model_PC_Write", PC_Write, e_pc);
         chk("model_IF_ID_Write", IF_ID_Write, e_ifw);
         chk("model_ID_EX_Flush", ID_EX_Flush, e_bub);
         chk("model_IF_ID_Flush", IF_ID_Flush, e_sq);
         chk("model_Stalling", Stalling, e_st);
`ifdef HAZARD_PERF_EN
         chk("model_StallCount", StallCount, m_stalls);
         chk("model_FlushCount", FlushCount, m_flushes);
`else
         chk("model_StallCount", StallCount, 32'd0);
         chk("model_FlushCount", FlushCount, 32'd0);
`endif
         if (!reset_n) begin
            m_pending = 0;
            m_stalls  = 0;
            m_flushes = 0;
         end else if (!MemWait) begin
            if (m_pending > 0) m_pending--;
            else if (n > 0) m_pending = n - 1;
            m_stalls  += 32'(e_bub);
            m_flushes += 32'(e_sq);
         end
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic clear_in();
      IF_ID_OpCode = '0; IF_ID_Funct = '0; IF_ID_Rs = '0; IF_ID_Rt = '0;
      IF_ID_UseRs = 1'b0; IF_ID_UseRt = 1'b0;
      ID_EX_MemRead = 1'b0; ID_EX_RegWrite = 1'b0; ID_EX_RegWrAddr = '0;
      EX_MEM_MemRead = 1'b0; EX_MEM_RegWrAddr = '0;
      BranchTaken = 1'b0; Jump = 1'b0; MemWait = 1'b0;
   endtask

   task automatic set_id(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rs,
                         input logic [4:0] rt, input logic urs, input logic urt);
      IF_ID_OpCode = op; IF_ID_Funct = fn; IF_ID_Rs = rs; IF_ID_Rt = rt;
      IF_ID_UseRs = urs; IF_ID_UseRt = urt;
   endtask

   task automatic set_ex(input logic mr, input logic rw, input logic [4:0] a);
      ID_EX_MemRead = mr; ID_EX_RegWrite = rw; ID_EX_RegWrAddr = a;
   endtask

   task automatic set_mem(input logic mr, input logic [4:0] a);
      EX_MEM_MemRead = mr; EX_MEM_RegWrAddr = a;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      reset_n = 1'b0;
      clear_in();
      next_cycle();
      next_cycle();
      started = 1'b1;
      settle();
      chk("reset_pc", PC_Write, 0);
      chk("reset_ifid_w", IF_ID_Write, 0);
      chk("reset_bubble", ID_EX_Flush, 1);
      chk("reset_squash", IF_ID_Flush, 1);
      chk("reset_stalling", Stalling, 0);

      // lw $t0 in EX, add reading $t0 in ID: one bubble
      next_cycle(); reset_n = 1'b1;
      set_ex(1, 1, 5'd8); set_id(6'h00, 6'h20, 5'd8, 5'd9, 1, 1); settle();
      chk("lu_pc", PC_Write, 0);
      chk("lu_ifid_w", IF_ID_Write, 0);
      chk("lu_bubble", ID_EX_Flush, 1);
      chk("lu_stalling", Stalling, 1);
      next_cycle(); set_ex(0, 0, 5'd0); set_mem(1, 5'd8); settle();
      chk("lu_resume_pc", PC_Write, 1);
      chk("lu_resume_stalling", Stalling, 0);

      // lw $t0 in EX, beq on rt=$t0: two stall cycles, branch ignored meanwhile
      next_cycle(); set_mem(0, 5'd0); set_ex(1, 1, 5'd8);
      set_id(6'h04, 6'h00, 5'd9, 5'd8, 1, 1); BranchTaken = 1'b1; settle();
      chk("br2_c1_pc", PC_Write, 0);
      chk("br2_c1_squash", IF_ID_Flush, 0);
      chk("br2_c1_stalling", Stalling, 1);
      next_cycle(); set_ex(0, 0, 5'd0); set_mem(1, 5'd8); settle();
      chk("br2_c2_bubble", ID_EX_Flush, 1);
      chk("br2_c2_stalling", Stalling, 1);
      next_cycle(); set_mem(0, 5'd0); settle();
      chk("br2_c3_pc", PC_Write, 1);
      chk("br2_c3_squash", IF_ID_Flush, 1);
      chk("br2_c3_stalling", Stalling, 0);

      // writer to $0 never stalls
      next_cycle(); BranchTaken = 1'b0; set_ex(0, 1, 5'd0);
      set_id(6'h04, 6'h00, 5'd0, 5'd0, 1, 1); settle();
      chk("zero_pc", PC_Write, 1);
      chk("zero_stalling", Stalling, 0);

      // MemWait for three cycles in the middle of a two-cycle stall
      next_cycle(); set_ex(1, 1, 5'd8); set_id(6'h05, 6'h00, 5'd8, 5'd0, 1, 1); settle();
      chk("mw_c1_stalling", Stalling, 1);
      next_cycle(); set_ex(0, 0, 5'd0); set_mem(1, 5'd8); MemWait = 1'b1;
      for (int i = 0; i < 3; i++) begin
         if (i > 0) next_cycle();
         settle();
         chk("mw_freeze_pc", PC_Write, 0);
         chk("mw_freeze_ifid_w", IF_ID_Write, 0);
         chk("mw_freeze_bubble", ID_EX_Flush, 0);
         chk("mw_freeze_squash", IF_ID_Flush, 0);
      end
      next_cycle(); MemWait = 1'b0; settle();
      chk("mw_tail_bubble", ID_EX_Flush, 1);
      chk("mw_tail_stalling", Stalling, 1);
      next_cycle(); set_mem(0, 5'd0); settle();
      chk("mw_run_pc", PC_Write, 1);
      chk("mw_run_stalling", Stalling, 0);

      // reset while in HOLD aborts the stall
      next_cycle(); set_ex(1, 1, 5'd8); set_id(6'h04, 6'h00, 5'd8, 5'd0, 1, 0); settle();
      chk("rh_c1_stalling", Stalling, 1);
      next_cycle(); reset_n = 1'b0; settle();
      chk("rh_forced_pc", PC_Write, 0);
      chk("rh_forced_bubble", ID_EX_Flush, 1);
      chk("rh_forced_squash", IF_ID_Flush, 1);
      chk("rh_forced_stalling", Stalling, 0);
      next_cycle(); reset_n = 1'b1; clear_in(); settle();
      chk("rh_after_pc", PC_Write, 1);
      chk("rh_after_bubble", ID_EX_Flush, 0);
      chk("rh_after_stalling", Stalling, 0);
      chk("rh_after_stallcnt", StallCount, 0);
      chk("rh_after_flushcnt", FlushCount, 0);

      // five load-use stalls and three jumps
      for (int i = 0; i < 5; i++) begin
         next_cycle(); set_ex(1, 1, 5'd8); set_id(6'h00, 6'h20, 5'd3, 5'd8, 1, 1); settle();
         next_cycle(); clear_in(); settle();
      end
      for (int i = 0; i < 3; i++) begin
         next_cycle(); IF_ID_OpCode = 6'h02; Jump = 1'b1; settle();
         chk("jump_squash", IF_ID_Flush, 1);
         next_cycle(); clear_in(); settle();
      end
`ifdef HAZARD_PERF_EN
      chk("perf_stallcnt", StallCount, 5);
      chk("perf_flushcnt", FlushCount, 3);
`else
      chk("perf_stallcnt", StallCount, 0);
      chk("perf_flushcnt", FlushCount, 0);
`endif
      next_cycle();
      started = 1'b0;
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
